// File: rtl/mdio_master_if.sv
// Host-side MIIM request/response bundle for the Clause-45 MDIO master.
// The host drives the request fields; the MDIO master answers with ready,
// read data and a read-valid pulse.
interface mdio_master_if;
    logic        host_req;
    logic        host_miim_sel;
    logic [1:0]  host_opcode;
    logic [9:0]  host_addr;
    logic [15:0] host_wr_data;
    logic        host_miim_rdy;
    logic [15:0] miim_rd_data;
    logic        miim_rd_vld;

    modport master (
        output host_req, host_miim_sel, host_opcode, host_addr, host_wr_data,
        input  host_miim_rdy, miim_rd_data, miim_rd_vld
    );

    modport slave (
        input  host_req, host_miim_sel, host_opcode, host_addr, host_wr_data,
        output host_miim_rdy, miim_rd_data, miim_rd_vld
    );
endinterface

// File: rtl/mdio_master.sv
// Clause-45 MDIO (MIIM) master.
// Accepts one host request at a time and serialises a 64-bit management frame
// (preamble, ST, OP, PRTAD, DEVAD, TA, DATA) MSB first on mdc/mdio. For read
// opcodes the pad is released from the turnaround onwards and the 16 data bits
// are captured on each mdc rising edge.
module mdio_master #(
    parameter int MDC_DIV = 20,  // host_clk cycles per mdc half-period (2..255)
    parameter int PRE_LEN = 32   // preamble length in bits (1..32)
) (
    input  logic         host_clk,
    input  logic         reset,
    mdio_master_if.slave host,
    output logic         mdc,
    input  logic         mdio_in,
    output logic         mdio_out,
    output logic         mdio_tri
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRE,
        S_HDR,
        S_TA,
        S_DATA,
        S_DONE
    } state_t;

    localparam logic [7:0] DIV_LAST = 8'(MDC_DIV - 1);
    localparam logic [4:0] PRE_LAST = 5'(PRE_LEN - 1);

    state_t      state_q, state_d;
    logic [7:0]  div_q, div_d;          // host_clk count within the current mdc half
    logic [4:0]  bit_q, bit_d;          // bit index within the current state
    logic        mdc_q, mdc_d;
    logic        out_q, out_d;
    logic        tri_q, tri_d;
    logic [31:0] tx_q, tx_d;            // ST/OP/PRTAD/DEVAD/TA/DATA, shifted out MSB first
    logic [15:0] rx_q, rx_d;            // read data, shifted in MSB first
    logic        rd_q, rd_d;            // current frame is a read / read-increment
    logic [15:0] rd_data_q, rd_data_d;
    logic        rd_vld_q, rd_vld_d;

    logic        accept;
    logic        half_end;
    logic        last_bit;
    state_t      state_after;

    assign accept   = host.host_req & host.host_miim_sel & (state_q == S_IDLE);
    assign half_end = (div_q == DIV_LAST);

    // Last bit of each frame section and the section that follows it.
    always_comb begin
        last_bit    = 1'b0;
        state_after = S_IDLE;
        unique case (state_q)
            S_PRE:   begin last_bit = (bit_q == PRE_LAST); state_after = S_HDR;  end
            S_HDR:   begin last_bit = (bit_q == 5'd13);    state_after = S_TA;   end
            S_TA:    begin last_bit = (bit_q == 5'd1);     state_after = S_DATA; end
            S_DATA:  begin last_bit = (bit_q == 5'd15);    state_after = S_DONE; end
            default: begin last_bit = 1'b0;                state_after = S_IDLE; end
        endcase
    end

    // Next-state and next-output logic; all pad outputs are registered so they
    // only move on the host_clk edge that starts a bit or an mdc half.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves one unassigned (no latches).
        state_d   = state_q;
        div_d     = div_q;
        bit_d     = bit_q;
        mdc_d     = mdc_q;
        out_d     = out_q;
        tri_d     = tri_q;
        tx_d      = tx_q;
        rx_d      = rx_q;
        rd_d      = rd_q;
        rd_data_d = rd_data_q;
        rd_vld_d  = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                mdc_d = 1'b0;
                out_d = 1'b1;
                tri_d = 1'b1;
                if (accept) begin
                    state_d = S_PRE;
                    div_d   = 8'd0;
                    bit_d   = 5'd0;
                    tx_d    = {2'b00, host.host_opcode, host.host_addr, 2'b10, host.host_wr_data};
                    rd_d    = host.host_opcode[1];
                    out_d   = 1'b1;
                    tri_d   = 1'b0;
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
                mdc_d   = 1'b0;
                out_d   = 1'b1;
                tri_d   = 1'b1;
            end

            default: begin
                if (!half_end) begin
                    div_d = div_q + 8'd1;
                end else begin
                    div_d = 8'd0;
                    mdc_d = ~mdc_q;
                    if (!mdc_q) begin
                        // mdc rising: the PHY's data bit is stable here.
                        if (state_q == S_DATA && rd_q) begin
                            rx_d = {rx_q[14:0], mdio_in};
                        end
                    end else begin
                        // mdc falling: end of bit, advance and present the next one.
                        if (last_bit) begin
                            state_d = state_after;
                            bit_d   = 5'd0;
                        end else begin
                            bit_d = bit_q + 5'd1;
                        end

                        if (state_d == S_DONE) begin
                            out_d = 1'b1;
                            tri_d = 1'b1;
                            if (rd_q) begin
                                rd_data_d = rx_q;
                                rd_vld_d  = 1'b1;
                            end
                        end else if (state_d == S_PRE) begin
                            out_d = 1'b1;
                            tri_d = 1'b0;
                        end else begin
                            out_d = tx_q[31];
                            tx_d  = {tx_q[30:0], 1'b0};
                            tri_d = rd_q && (state_d == S_TA || state_d == S_DATA);
                        end
                    end
                end
            end
        endcase
    end

    // State and datapath registers; reset aborts any frame in progress.
    always_ff @(posedge host_clk or negedge reset) begin
        if (!reset) begin
            // NOTE: the shift registers are ordinary flops, so they are cleared with everything else.
            state_q   <= S_IDLE;
            div_q     <= 8'd0;
            bit_q     <= 5'd0;
            mdc_q     <= 1'b0;
            out_q     <= 1'b1;
            tri_q     <= 1'b1;
            tx_q      <= 32'd0;
            rx_q      <= 16'd0;
            rd_q      <= 1'b0;
            rd_data_q <= 16'd0;
            rd_vld_q  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register updates from pre-edge values.
            state_q   <= state_d;
            div_q     <= div_d;
            bit_q     <= bit_d;
            mdc_q     <= mdc_d;
            out_q     <= out_d;
            tri_q     <= tri_d;
            tx_q      <= tx_d;
            rx_q      <= rx_d;
            rd_q      <= rd_d;
            rd_data_q <= rd_data_d;
            rd_vld_q  <= rd_vld_d;
        end
    end

    assign host.host_miim_rdy = (state_q == S_IDLE);
    assign host.miim_rd_data  = rd_data_q;
    assign host.miim_rd_vld   = rd_vld_q;
    assign mdc                = mdc_q;
    assign mdio_out           = out_q;
    assign mdio_tri           = tri_q;

endmodule
